// File: rtl/k12a_io_serial.sv
`default_nettype none
// ============================================================================
// Module   : k12a_io_serial_fifo
// Purpose  : Small synchronous byte FIFO used for the UART TX and RX queues.
//            A push into a full FIFO is still accepted when a pop happens on
//            the same edge, because the pop frees the slot being written.
// Ports    : clock, reset         - clock and synchronous active-high reset
//            push_i, push_data_i  - write request and data
//            pop_i                - read request (head is consumed on the edge)
//            head_o               - current head entry (valid when !empty_o)
//            empty_o, full_o      - occupancy flags
//            push_ok_o            - the push this cycle is accepted
// Revision : 1.0 - initial release
// ============================================================================
module k12a_io_serial_fifo #(
  parameter int DEPTH = 4,  // power of two, at least 2
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             push_ok_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic             w_do_pop;
  logic             w_do_push;

  // Pointers carry one extra wrap bit so that full and empty are distinct.
  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);
  assign push_ok_o = w_do_push;
  assign head_o    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (w_do_push) wr_q <= wr_q + PW'(1);
      if (w_do_pop)  rd_q <= rd_q + PW'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clock) begin
    if (w_do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// ============================================================================
// Module   : k12a_io_serial
// Purpose  : IO-space responder for the K12a core. Provides an 8N1 UART
//            (TX and RX, each with a byte FIFO), a status/control register
//            pair and the registered wake request sampled by the halted CPU.
// Ports    : clock, reset   - system clock, synchronous active-high reset
//            io_addr        - IO register select (0 DATA, 1 STATUS, 2 CTRL)
//            io_load        - one-cycle CPU read strobe
//            io_store       - one-cycle CPU write strobe
//            data_in        - write data during io_store
//            data_out       - read data, 0x00 unless io_load is high
//            wake           - registered wake request
//            rx             - asynchronous serial input
//            tx             - serial output, idle high
// Revision : 1.0 - initial release
// ============================================================================
module k12a_io_serial #(
  parameter int CLKS_PER_BIT = 16,  // >= 4 and even
  parameter int FIFO_DEPTH   = 4    // power of two
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] io_addr,
  input  logic       io_load,
  input  logic       io_store,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       wake,
  input  logic       rx,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  // --------------------------------------------------------------------------
  // CPU register decode
  // --------------------------------------------------------------------------
  logic w_wr_data;
  logic w_wr_status;
  logic w_wr_ctrl;
  logic w_rd_data;

  assign w_wr_data   = io_store && (io_addr == 3'd0);
  assign w_wr_status = io_store && (io_addr == 3'd1);
  assign w_wr_ctrl   = io_store && (io_addr == 3'd2);
  assign w_rd_data   = io_load  && (io_addr == 3'd0);

  // --------------------------------------------------------------------------
  // FIFOs
  // --------------------------------------------------------------------------
  logic [7:0] tx_head;
  logic       tx_empty;
  logic       tx_full;
  logic       tx_push_ok;
  logic       tx_pop;

  logic [7:0] rx_head;
  logic       rx_empty;
  logic       rx_full;
  logic       rx_push_ok;
  logic       rx_push;
  logic [7:0] rx_shift_q;
  logic [7:0] rx_shift_d;

  k12a_io_serial_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (w_wr_data),
    .push_data_i (data_in),
    .pop_i       (tx_pop),
    .head_o      (tx_head),
    .empty_o     (tx_empty),
    .full_o      (tx_full),
    .push_ok_o   (tx_push_ok)
  );

  k12a_io_serial_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (rx_push),
    .push_data_i (rx_shift_q),
    .pop_i       (w_rd_data),
    .head_o      (rx_head),
    .empty_o     (rx_empty),
    .full_o      (rx_full),
    .push_ok_o   (rx_push_ok)
  );

  // --------------------------------------------------------------------------
  // TX state machine
  // --------------------------------------------------------------------------
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;
  logic          w_tx_idle;

  assign w_tx_idle = tx_empty && (tx_state_q == S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    tx_d       = 1'b1;

    case (tx_state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = '0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == c_BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == c_BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt_q == c_BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = S_IDLE;
    endcase

    // The line level is registered from the next state so tx is glitch-free
    // and changes on the same edge as the state.
    case (tx_state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

  // --------------------------------------------------------------------------
  // RX synchroniser and state machine
  // --------------------------------------------------------------------------
  // s1/s2 form the synchroniser; s3 holds the previous synchronised level
  // for falling-edge detection. All reset high to match an idle line.
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  uart_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic          w_frame_set;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    w_frame_set = 1'b0;

    case (rx_state_q)
      S_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        // Half a bit after the edge we sit mid start bit; a high line here
        // means the low pulse was a glitch.
        if (rx_cnt_q == c_HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == c_BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == c_BIT_LAST) begin
          rx_cnt_d    = '0;
          rx_state_d  = S_IDLE;
          rx_push     = rx_s2_q;
          w_frame_set = ~rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sticky error bits {tx_ovf, frame_err, rx_ovf}, CTRL and wake
  // --------------------------------------------------------------------------
  logic [2:0] err_q;
  logic [2:0] w_err_set;
  logic [2:0] w_err_clr;
  logic [1:0] ctrl_q;
  logic       wake_q;
  logic [7:0] w_status;

  assign w_err_set = {w_wr_data & ~tx_push_ok, w_frame_set, rx_push & ~rx_push_ok};
  assign w_err_clr = w_wr_status ? data_in[5:3] : 3'b000;
  assign w_status  = {2'b00, err_q, w_tx_idle, tx_full, ~rx_empty};

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q  <= '0;
      ctrl_q <= '0;
      wake_q <= 1'b0;
    end else begin
      // Set is applied after clear so a same-cycle set wins.
      err_q  <= (err_q & ~w_err_clr) | w_err_set;
      if (w_wr_ctrl) ctrl_q <= data_in[1:0];
      wake_q <= (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & w_tx_idle);
    end
  end

  assign wake = wake_q;

  // rx_full is implied by push_ok; kept visible for debug only.
  logic w_unused;
  assign w_unused = rx_full;

  always_comb begin
    data_out = 8'h00;
    if (io_load) begin
      case (io_addr)
        3'd0:    data_out = rx_empty ? 8'h00 : rx_head;
        3'd1:    data_out = w_status;
        3'd2:    data_out = {6'b000000, ctrl_q};
        default: data_out = 8'h00;
      endcase
    end
  end

endmodule
`default_nettype wire
